// File: rtl/lsu_mem_if_if.sv
// Bus bundle between the core execute stage, lsu_mem_if and data_mem.
// "slave" is the LSU view. "master" is the core/memory environment view.
`ifndef D_WIDTH
`define D_WIDTH 32
`endif
`ifndef D_ADD_SIZE
`define D_ADD_SIZE 10
`endif

interface lsu_mem_if_if #(
  parameter int WIDTH    = `D_WIDTH,
  parameter int ADD_SIZE = `D_ADD_SIZE
);
  logic                i_req;
  logic                i_we;
  logic [2:0]          i_funct3;
  logic [ADD_SIZE-1:0] i_add;
  logic [WIDTH-1:0]    i_wdata;
  logic                o_ready;
  logic                o_rvalid;
  logic [WIDTH-1:0]    o_rdata;
  logic                o_done;
  logic                o_fault;
  logic                o_mem_we;
  logic [ADD_SIZE-1:0] o_mem_add;
  logic [WIDTH-1:0]    i_mem_rdata;
  logic [WIDTH-1:0]    o_mem_wdata;

  modport slave (
    input  i_req, i_we, i_funct3, i_add, i_wdata, i_mem_rdata,
    output o_ready, o_rvalid, o_rdata, o_done, o_fault,
           o_mem_we, o_mem_add, o_mem_wdata
  );

  modport master (
    output i_req, i_we, i_funct3, i_add, i_wdata, i_mem_rdata,
    input  o_ready, o_rvalid, o_rdata, o_done, o_fault,
           o_mem_we, o_mem_add, o_mem_wdata
  );
endinterface

// File: rtl/lsu_mem_if.sv
// RV32I load/store unit in front of a word-wide data_mem with no byte enables.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module lsu_mem_if #(
  parameter int WIDTH    = `D_WIDTH,
  parameter int ADD_SIZE = `D_ADD_SIZE
) (
  input logic         i_clk,
  input logic         i_rstn,
  lsu_mem_if_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] SWRITE = 3'd3;
  localparam logic [2:0] FAULT  = 3'd4;

  logic [2:0]          state;
  logic [2:0]          f3_q;
  logic [1:0]          add_lo_q;
  logic [15:0]         wdata_q;
  logic [WIDTH-1:0]    rdata_q;
  logic [WIDTH-1:0]    mem_wdata_q;
  logic [ADD_SIZE-1:0] mem_add_q;
  logic                rvalid_q;
  logic                done_q;
  logic                fault_q;
  logic                legal;
  logic                misaligned;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [WIDTH-1:0]    load_fmt;
  logic [WIDTH-1:0]    merge;

  always_comb begin
    legal = 1'b0;
    case (bus.i_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !bus.i_we;
      default:                legal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (bus.i_funct3[1:0])
      2'b01:   misaligned = bus.i_add[0];
      2'b10:   misaligned = |bus.i_add[1:0];
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    byte_sel = bus.i_mem_rdata[{add_lo_q, 3'b000} +: 8];
    half_sel = bus.i_mem_rdata[{add_lo_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  load_fmt = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_fmt = {{(WIDTH-16){half_sel[15]}}, half_sel};
      3'b100:  load_fmt = {{(WIDTH-8){1'b0}}, byte_sel};
      3'b101:  load_fmt = {{(WIDTH-16){1'b0}}, half_sel};
      default: load_fmt = bus.i_mem_rdata;
    endcase
  end

  // SB uses funct3 000 and SH uses 001, so funct3[0] picks the lane size.
  always_comb begin
    merge = bus.i_mem_rdata;
    if (f3_q[0]) merge[{add_lo_q[1], 4'b0000} +: 16] = wdata_q;
    else         merge[{add_lo_q, 3'b000} +: 8]      = wdata_q[7:0];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      f3_q        <= 3'b000;
      add_lo_q    <= 2'b00;
      wdata_q     <= 16'h0000;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      mem_add_q   <= '0;
      rvalid_q    <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_req) begin
            f3_q      <= bus.i_funct3;
            add_lo_q  <= bus.i_add[1:0];
            wdata_q   <= bus.i_wdata[15:0];
            mem_add_q <= {bus.i_add[ADD_SIZE-1:2], 2'b00};
            if (!legal || misaligned) begin
              state <= FAULT;
            end else if (!bus.i_we) begin
              state <= LOAD;
            end else if (bus.i_funct3 == 3'b010) begin
              mem_wdata_q <= bus.i_wdata;
              state       <= SWRITE;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          rdata_q  <= load_fmt;
          rvalid_q <= 1'b1;
          done_q   <= 1'b1;
          state    <= IDLE;
        end
        RMW_RD: begin
          mem_wdata_q <= merge;
          state       <= SWRITE;
        end
        SWRITE: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        FAULT: begin
          fault_q <= 1'b1;
          done_q  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready     = (state == IDLE);
  assign bus.o_mem_we    = (state == SWRITE);
  assign bus.o_mem_add   = mem_add_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_rvalid    = rvalid_q;
  assign bus.o_done      = done_q;
  assign bus.o_fault     = fault_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: directed vector table, reset-abort sequence, and random
// traffic checked against a byte-arithmetic reference of the load/store rules.
module tb_lsu_mem_if;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [9:0]  add;
    logic [31:0] wdata;
    logic        exp_fault;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk;
  logic        rstn;
  logic        mem_clear;
  logic [31:0] phys_mem [0:255];
  logic [31:0] ref_mem  [0:255];
  logic [31:0] last_rdata;
  int          total;
  int          bad;
  vec_t        vecs [18];

  lsu_mem_if_if #(.WIDTH(32), .ADD_SIZE(10)) bus ();

  lsu_mem_if #(.WIDTH(32), .ADD_SIZE(10)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for data_mem: combinational read, write on the rising edge.
  assign bus.i_mem_rdata = phys_mem[bus.o_mem_add[9:2]];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) phys_mem[i] <= 32'h0;
    end else if (bus.o_mem_we) begin
      phys_mem[bus.o_mem_add[9:2]] <= bus.o_mem_wdata;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference: access size from funct3, lanes and sign extension by arithmetic.
  task automatic modelOp(input logic we, input logic [2:0] f3, input int add, input logic [31:0] wdata,
                         output logic fault, output logic [31:0] rdata);
    longint one  = 1;
    longint word = longint'({32'd0, ref_mem[add / 4]});
    longint wd   = longint'({32'd0, wdata});
    longint val;
    longint mask;
    int     size;
    int     boff;
    bit     legal;
    bit     misal;
    rdata = 32'h0;
    case (f3)
      3'd0, 3'd1, 3'd2: legal = 1'b1;
      3'd4, 3'd5:       legal = !we;
      default:          legal = 1'b0;
    endcase
    size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    misal = (add % size) != 0;
    fault = !legal || (TRAP && misal);
    if (!fault) begin
      boff = (add % 4) / size * size;
      if (!we) begin
        val = (word >> (8 * boff)) % (one << (8 * size));
        if (f3 < 4 && size < 4 && val >= (one << (8 * size - 1))) val = val - (one << (8 * size));
        rdata = val[31:0];
      end else begin
        mask = ((one << (8 * size)) - 1) << (8 * boff);
        word = (word & ~mask) | ((wd % (one << (8 * size))) << (8 * boff));
        ref_mem[add / 4] = word[31:0];
      end
    end
  endtask

  // Issues one request at a negedge and follows it until o_done (bounded).
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [9:0] add,
                               input logic [31:0] wdata, input logic exp_fault, input logic [31:0] exp_rdata);
    int          done_cyc   = 0;
    int          rvalid_cnt = 0;
    int          fault_cnt  = 0;
    int          we_cnt     = 0;
    int          we_cyc     = 0;
    logic        ready_done = 1'b0;
    logic [9:0]  we_addr    = 10'h0;
    logic [31:0] exp_r;
    bit          is_load    = !we;
    bit          good_store = we && !exp_fault;
    int          exp_lat    = (good_store && f3 != 3'b010) ? 3 : 2;
    checkOutput("ready_at_issue", 32'(bus.o_ready), 32'd1);
    bus.i_req    = 1'b1;
    bus.i_we     = we;
    bus.i_funct3 = f3;
    bus.i_add    = add;
    bus.i_wdata  = wdata;
    @(posedge clk);
    for (int k = 1; k <= 10 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.i_req   = 1'b0;
        bus.i_wdata = $urandom;
      end
      if (bus.o_mem_we) begin
        we_cnt++;
        we_cyc  = k;
        we_addr = bus.o_mem_add;
      end
      if (bus.o_rvalid) rvalid_cnt++;
      if (bus.o_fault)  fault_cnt++;
      if (bus.o_done) begin
        done_cyc   = k;
        ready_done = bus.o_ready;
      end
    end
    if (is_load && !exp_fault) begin
      exp_r      = exp_rdata;
      last_rdata = exp_rdata;
    end else begin
      exp_r = last_rdata;
    end
    checkOutput("done_cycle", 32'(done_cyc), 32'(exp_lat));
    checkOutput("ready_at_done", 32'(ready_done), 32'd1);
    checkOutput("fault_pulses", 32'(fault_cnt), 32'(exp_fault));
    checkOutput("rvalid_pulses", 32'(rvalid_cnt), 32'(is_load && !exp_fault));
    checkOutput("mem_we_cycles", 32'(we_cnt), 32'(good_store));
    checkOutput("rdata", bus.o_rdata, exp_r);
    if (good_store) begin
      checkOutput("mem_we_when", 32'(we_cyc), 32'(exp_lat - 1));
      checkOutput("mem_add", 32'(we_addr), 32'({add[9:2], 2'b00}));
    end
  endtask

  initial begin
    logic        m_fault;
    logic [31:0] m_rdata;
    int          mism;
    total = 0;
    bad   = 0;
    last_rdata = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    rstn         = 1'b0;
    mem_clear    = 1'b1;
    bus.i_req    = 1'b0;
    bus.i_we     = 1'b0;
    bus.i_funct3 = 3'b000;
    bus.i_add    = 10'h0;
    bus.i_wdata  = 32'h0;

    vecs[0]  = '{1'b1, 3'b010, 10'h010, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 3'b010, 10'h010, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 3'b010, 10'h020, 32'h11223344, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 3'b000, 10'h022, 32'h000000AA, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 3'b010, 10'h020, 32'h0,        1'b0, 32'h11AA3344};
    vecs[5]  = '{1'b0, 3'b000, 10'h022, 32'h0,        1'b0, 32'hFFFFFFAA};
    vecs[6]  = '{1'b0, 3'b100, 10'h022, 32'h0,        1'b0, 32'h000000AA};
    vecs[7]  = '{1'b1, 3'b010, 10'h024, 32'h0,        1'b0, 32'h0};
    vecs[8]  = '{1'b1, 3'b001, 10'h026, 32'h00008001, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 3'b010, 10'h024, 32'h0,        1'b0, 32'h80010000};
    vecs[10] = '{1'b0, 3'b001, 10'h026, 32'h0,        1'b0, 32'hFFFF8001};
    vecs[11] = '{1'b0, 3'b101, 10'h026, 32'h0,        1'b0, 32'h00008001};
    vecs[12] = '{1'b0, 3'b010, 10'h021, 32'h0,        TRAP, 32'h11AA3344};
    vecs[13] = '{1'b1, 3'b001, 10'h023, 32'h00001234, TRAP, 32'h0};
    vecs[14] = '{1'b0, 3'b010, 10'h020, 32'h0,        1'b0, TRAP ? 32'h11AA3344 : 32'h12343344};
    vecs[15] = '{1'b0, 3'b011, 10'h020, 32'h0,        1'b1, 32'h0};
    vecs[16] = '{1'b1, 3'b100, 10'h020, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[17] = '{1'b0, 3'b010, 10'h020, 32'h0,        1'b0, TRAP ? 32'h11AA3344 : 32'h12343344};

    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_clear = 1'b0;
    checkOutput("rst_ready", 32'(bus.o_ready), 32'd1);
    checkOutput("rst_flags", 32'({bus.o_rvalid, bus.o_done, bus.o_fault, bus.o_mem_we}), 32'd0);
    checkOutput("rst_rdata", bus.o_rdata, 32'h0);
    checkOutput("rst_mem_add", 32'(bus.o_mem_add), 32'h0);
    checkOutput("rst_mem_wdata", bus.o_mem_wdata, 32'h0);
    rstn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      modelOp(vecs[i].we, vecs[i].f3, int'(vecs[i].add), vecs[i].wdata, m_fault, m_rdata);
      applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].add, vecs[i].wdata, vecs[i].exp_fault, vecs[i].exp_rdata);
    end

    // Reset while an SB sits in RMW_RD: no write may follow and outputs clear.
    bus.i_req    = 1'b1;
    bus.i_we     = 1'b1;
    bus.i_funct3 = 3'b000;
    bus.i_add    = 10'h021;
    bus.i_wdata  = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    bus.i_req = 1'b0;
    rstn = 1'b0;
    #1;
    checkOutput("abort_mem_we", 32'(bus.o_mem_we), 32'd0);
    checkOutput("abort_ready", 32'(bus.o_ready), 32'd1);
    checkOutput("abort_flags", 32'({bus.o_rvalid, bus.o_done, bus.o_fault}), 32'd0);
    checkOutput("abort_rdata", bus.o_rdata, 32'h0);
    checkOutput("abort_mem_add", 32'(bus.o_mem_add), 32'h0);
    checkOutput("abort_mem_wdata", bus.o_mem_wdata, 32'h0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("abort_hold_we", 32'({bus.o_mem_we, bus.o_done}), 32'd0);
    end
    rstn = 1'b1;
    last_rdata = 32'h0;
    checkOutput("abort_word", phys_mem[8], ref_mem[8]);
    modelOp(1'b0, 3'b010, 32, 32'h0, m_fault, m_rdata);
    applyStimulus(1'b0, 3'b010, 10'h020, 32'h0, m_fault, m_rdata);

    for (int n = 0; n < 300; n++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [9:0]  r_add;
      logic [31:0] r_wd;
      r_we  = 1'($urandom_range(1, 0));
      r_f3  = 3'($urandom_range(7, 0));
      r_add = 10'($urandom_range(31, 0));
      r_wd  = $urandom;
      modelOp(r_we, r_f3, int'(r_add), r_wd, m_fault, m_rdata);
      applyStimulus(r_we, r_f3, r_add, r_wd, m_fault, m_rdata);
    end

    @(negedge clk);
    mism = 0;
    for (int i = 0; i < 256; i++) if (phys_mem[i] !== ref_mem[i]) mism++;
    checkOutput("mem_sweep_mismatch_words", 32'(mism), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_if.md
# lsu_mem_if

Load/store unit between the RV32I core's execute stage and `data_mem`. It accepts one load or store request at a time and formats sub-word load data with sign or zero extension. Byte and halfword stores are done as read-modify-write on the word-wide memory, which has no byte enables. Misaligned accesses and illegal `funct3` codes are detected and reported, and the core is stalled until each access completes.

## Interface
Parameters:
- `WIDTH`, default `` `D_WIDTH `` (32): data word width. Only 32 is supported.
- `ADD_SIZE`, default `` `D_ADD_SIZE ``: byte-address width. It matches `data_mem` `i_add`.

Ports:
- `i_clk`, input, 1: clock. Everything is rising-edge.
- `i_rstn`, input, 1: asynchronous, active-low reset.
- `i_req`, input, 1: core request valid.
- `i_we`, input, 1: 1 = store, 0 = load.
- `i_funct3`, input, 3: RV32I load/store `funct3`.
- `i_add`, input, `ADD_SIZE`: byte address.
- `i_wdata`, input, `WIDTH`: store data, right-aligned.
- `o_ready`, output, 1: 1 when idle and able to accept a request.
- `o_rvalid`, output, 1: one-cycle pulse; `o_rdata` is valid.
- `o_rdata`, output, `WIDTH`: formatted load result, registered.
- `o_done`, output, 1: one-cycle pulse at completion of any accepted request, including faults.
- `o_fault`, output, 1: one-cycle pulse together with `o_done` when a request is rejected.
- `o_mem_we`, output, 1: to `data_mem` `i_we`.
- `o_mem_add`, output, `ADD_SIZE`: to `data_mem` `i_add`. The low two bits are always 0.
- `i_mem_rdata`, input, `WIDTH`: from `data_mem` `o_data`, which is a combinational read.
- `o_mem_wdata`, output, `WIDTH`: to `data_mem` `i_data`.

## Operation
- **Accept.** A request is accepted on the rising edge where `i_req && o_ready`. On acceptance the unit registers `i_we`, `i_funct3`, `i_add` and `i_wdata`. Requests while `o_ready=0` are ignored; the core holds them.
- **Legal `funct3` codes.**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal and goes to FAULT.
- **Alignment rule.** Halfword accesses need `add[0]=0`. Word accesses need `add[1:0]=00`. See Configuration for what happens on violation.
- **States and transitions:**
  - IDLE → LOAD (load), SWRITE (SW), RMW_RD (SB/SH) or FAULT.
  - LOAD → IDLE.
  - RMW_RD → SWRITE.
  - SWRITE → IDLE.
  - FAULT → IDLE.
- **LOAD.**
  - Drive `o_mem_add = {add[ADD_SIZE-1:2],2'b00}`.
  - Select the byte (`add[1:0]`) or halfword (`add[1]`) from `i_mem_rdata`.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU, pass through for LW.
  - Register the result into `o_rdata`.
- **RMW_RD.** Drive the word address and capture `i_mem_rdata` into the merge register.
- **SWRITE.**
  - Assert `o_mem_we` with the word address.
  - SW: `o_mem_wdata = wdata`.
  - SB: the merge register with byte lane `add[1:0]` replaced by `wdata[7:0]`.
  - SH: the merge register with halfword lane `add[1]` replaced by `wdata[15:0]`.
- **FAULT.** Nothing is written and `o_rvalid` stays 0. `o_rdata` holds its previous value.
- **Memory-side outputs outside SWRITE.** `o_mem_we=0`. `o_mem_add` holds the last registered word address, and `o_mem_wdata` holds its last value.

## Timing
- **Reset values.**
  - State = IDLE and `o_ready=1`.
  - `o_rvalid`, `o_done`, `o_fault` and `o_mem_we` are 0.
  - `o_rdata`, `o_mem_add` and `o_mem_wdata` are 0.
- **Timeline.** Accept edge = cycle 0. The unit is in the state after IDLE during cycle 1.
- **Load.** `o_rdata` is updated at the end of cycle 1. `o_rvalid` and `o_done` pulse in cycle 2, with `o_ready=1` in that same cycle. Back-to-back issue is allowed, giving a throughput of one load every 2 cycles.
- **SW.** `o_mem_we=1` during cycle 1, and memory is written at the end of cycle 1. `o_done` pulses in cycle 2.
- **SB/SH.**
  - Read happens in cycle 1.
  - `o_mem_we=1` during cycle 2, and memory is written at the end of cycle 2.
  - `o_done` pulses in cycle 3.
- **Fault.** `o_fault` and `o_done` pulse in cycle 2.
- **Pulses.** `o_done`, `o_rvalid` and `o_fault` are registered pulses, exactly one cycle long.
- **`o_mem_we`.** Decoded from state only, never from core inputs.
- **Reset mid-operation.** State goes to IDLE immediately and `o_mem_we` drops asynchronously. A pending RMW is abandoned with no partial write. No `o_done` follows.
- **Request and completion pulse in the same cycle.** A request that arrives while a completion pulse is showing is accepted normally, because `o_ready=1` then.

## Configuration
- **Macro `LSU_MISALIGN_TRAP_EN`.**
- **Defined.** An alignment violation sends the request to FAULT: `o_fault` pulses, and there is no write and no `o_rvalid`.
- **Undefined.** No alignment check is made.
  - The word address is `add[ADD_SIZE-1:2]`.
  - LH/LHU/SH use lane `add[1]`, ignoring `add[0]`.
  - LW/SW ignore `add[1:0]`.
- **Either way.** Illegal `funct3` codes always fault.

## Test plan
- **SW then LW.** SW `0xDEADBEEF` @`0x10`, then LW @`0x10`. Required: `o_mem_we` high exactly one cycle, and `o_rdata=0xDEADBEEF` with `o_rvalid` in cycle 2.
- **Byte RMW.** Word `0x11223344` @`0x20`, then SB `0xAA` @`0x22`. Required: the word becomes `0x11AA3344` and `o_done` pulses in cycle 3. Then LB @`0x22` returns `0xFFFFFFAA` and LBU returns `0x000000AA`.
- **Halfword RMW.** SH `0x8001` @`0x26` on word `0`. Required: the word becomes `0x80010000`. Then LH @`0x26` returns `0xFFFF8001` and LHU returns `0x00008001`.
- **Misaligned with the macro defined.** LW @`0x21` and SH @`0x23`. Required: `o_fault` and `o_done` pulse in cycle 2, memory is unchanged, and `o_rvalid` stays 0. Without the macro, LW @`0x21` returns the word at `0x20`.
- **Illegal `funct3`.** `funct3=011` load and `funct3=100` store. Required: both fault, with no write.
- **Reset during a byte store.** Assert `i_rstn=0` during RMW_RD of an SB. Required: `o_mem_we` never asserts, the word is unchanged, and all outputs hold their reset values. A new request is accepted the first cycle after reset is released.
